// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// RV32I instruction fetch stage that sits directly in front of the decoder.
// It walks a sequential word-address stream out to instruction memory and
// parks each returned word, tagged with its PC, in a small in-order queue.
// The decoder drains the queue head over a valid/ready handshake.
//
// A control-flow redirect flushes the queue and restarts fetch at the
// target. Requests already issued to memory cannot be recalled, so their
// responses are counted off and discarded as they come back.
//
// Ports
//   clk             in   1   clock, all state updates on the rising edge
//   rst_n           in   1   synchronous active-low reset
//   imem_req_valid  out  1   fetch request valid
//   imem_req_ready  in   1   memory accepts the request this cycle
//   imem_req_addr   out  32  word-aligned fetch address
//   imem_rsp_valid  in   1   response word valid (in order, never stalled)
//   imem_rsp_data   in   32  response instruction word
//   instr_valid     out  1   {instr, pc} valid to decode
//   instr_ready     in   1   decode consumes the head entry
//   instr           out  32  instruction word to the decoder
//   pc              out  32  address of instr
//   redirect_valid  in   1   control-flow redirect, single-cycle pulse
//   redirect_pc     in   32  redirect target (bits [1:0] ignored)
//
// Parameters
//   RESET_PC  first fetch address after reset
//   DEPTH     queue entries and maximum in-flight requests; power of 2, >= 2
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction memory request channel
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  // instruction memory response channel
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  // decode channel
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  // control-flow redirect
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Counters must be able to hold the value DEPTH itself.
  localparam int unsigned CNT_W = PTR_W + 1;
  // outstanding + count is compared one bit wider so the sum cannot wrap.
  localparam logic [CNT_W:0] DEPTH_SUM = (CNT_W + 1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]      fetch_pc_q,    fetch_pc_d;     // next address to request
  logic [31:0]      rsp_pc_q,      rsp_pc_d;       // PC of oldest live request
  logic [CNT_W-1:0] outstanding_q, outstanding_d;  // issued, not yet answered
  logic [CNT_W-1:0] drop_cnt_q,    drop_cnt_d;     // stale responses to discard
  logic [CNT_W-1:0] count_q,       count_d;        // queue occupancy
  logic [PTR_W-1:0] head_q,        head_d;
  logic [PTR_W-1:0] tail_q,        tail_d;

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];

  // ---------------------------------------------------------------------------
  // Datapath decisions for this cycle
  // ---------------------------------------------------------------------------
  logic [CNT_W:0] inflight_sum;
  logic [31:0]    redirect_target;
  logic           issue;
  logic           rsp_live;
  logic           rsp_discard;
  logic           push;
  logic           pop;

  // The two low bits of the target are simply dropped; only the word address
  // matters to this stage.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign redirect_target = {redirect_pc[31:2], 2'b00};

  // Every slot is reserved either by an in-flight request or by a queued
  // word, so a response always has room to land without back-pressure.
  assign inflight_sum = {1'b0, outstanding_q} + {1'b0, count_q};

  // Gating with rst_n keeps a request from being handshaken while the
  // memory is itself being reset.
  assign imem_req_valid = rst_n && !redirect_valid && (inflight_sum < DEPTH_SUM);
  assign imem_req_addr  = fetch_pc_q;
  assign issue          = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_live    = imem_rsp_valid && (outstanding_q != '0);
  assign rsp_discard = rsp_live && (drop_cnt_q != '0);
  // A response coinciding with a redirect belongs to the old stream.
  assign push        = rsp_live && (drop_cnt_q == '0) && !redirect_valid;

  // No bypass: only words already stored in the queue are visible.
  assign instr_valid = (count_q != '0);
  assign instr       = instr_mem[head_q];
  assign pc          = pc_mem[head_q];
  assign pop         = instr_valid && instr_ready && !redirect_valid;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every next-state signal gets its hold value before any branch, so
    // no path leaves one unassigned and no latch can be inferred.
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;

    // Outstanding tracks every issued request, discarded or not; a redirect
    // never issues, so only the response side can move it in that cycle.
    outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(rsp_live);

    if (redirect_valid) begin
      fetch_pc_d = redirect_target;
      rsp_pc_d   = redirect_target;
      // Everything still in flight after this cycle is stale. Recomputing
      // from outstanding makes back-to-back redirects come out right.
      drop_cnt_d = outstanding_q - CNT_W'(rsp_live);
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      // rsp_pc follows only the words that are kept; discarded ones belong
      // to a stream that has already been abandoned.
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        tail_d   = tail_q + PTR_W'(1);
      end
      if (rsp_discard) begin
        drop_cnt_d = drop_cnt_q - CNT_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments so every register
    // samples the values from before this edge, independent of block order.
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Queue storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; an entry is only read after it has
  // been written, because instr_valid is driven by the reset count.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      instr_mem[tail_q] <= imem_rsp_data;
      pc_mem[tail_q]    <= rsp_pc_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol and invariant checks
  // ---------------------------------------------------------------------------
  // Memory must never answer a request that was not made.
  a_rsp_has_req : assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (outstanding_q != '0));

  // Reserved slots never exceed the queue size.
  a_no_overfill : assert property (@(posedge clk) disable iff (!rst_n)
    inflight_sum <= DEPTH_SUM);

  // A stalled request keeps its address until accepted or redirected.
  a_addr_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (imem_req_valid && !imem_req_ready && !redirect_valid)
      |=> (imem_req_addr == $past(imem_req_addr)));

endmodule
